// File: rtl/multicycle_controller.sv
`timescale 1ns/1ps
// multicycle_controller
//   Multi-cycle control sequencer. Steps each instruction through
//   FETCH/DECODE/EXEC/MEM/WB and drives one state's control strobes at a time.
//   It waits on a variable-latency data memory, with a bounded timeout that
//   ends in a sticky FAULT. It also keeps a saturating count of retired
//   instructions.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               leaves IDLE/HALT into FETCH
//   typ, op             instruction type bit and opcode, captured in FETCH
//   mem_ack             data memory completion, only honoured in MEM
//   ir_load, pc_en      instruction register load, PC advance
//   br_ctrl             branch select
//   regwrite_ctrl       register file write
//   aluop_ctrl          ALU operation
//   mem_req             data memory request
//   memwrite_ctrl       data memory write
//   accdata_ctrl        accumulator source (00 imm, 01 mem, 10 reg, 11 ALU)
//   accwrite_ctrl       accumulator write
//   busy, done, err     executing / halted / faulted status
//   retired             saturating retired-instruction count
module multicycle_controller #(
    parameter int unsigned ALUOP_W     = 3,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               typ,
    input  logic [3:0]         op,
    input  logic               mem_ack,
    output logic               ir_load,
    output logic               pc_en,
    output logic               br_ctrl,
    output logic               regwrite_ctrl,
    output logic [ALUOP_W-1:0] aluop_ctrl,
    output logic               mem_req,
    output logic               memwrite_ctrl,
    output logic [1:0]         accdata_ctrl,
    output logic               accwrite_ctrl,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   retired
);

    localparam int unsigned TO_W   = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned INSN_W = 5;

    localparam logic [3:0] OP_STORE = 4'd0;
    localparam logic [3:0] OP_LB    = 4'd1;
    localparam logic [3:0] OP_SB    = 4'd2;
    localparam logic [3:0] OP_PUT   = 4'd3;
    localparam logic [3:0] OP_BTR   = 4'd4;
    localparam logic [3:0] OP_JMP   = 4'd5;
    localparam logic [3:0] OP_ADD   = 4'd6;
    localparam logic [3:0] OP_GTR   = 4'd13;
    localparam logic [3:0] OP_HALT  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_FAULT
    } state_e;

    state_e              state_q, state_d;
    logic [INSN_W-1:0]   insn_q, insn_d;       // {typ, op} captured in FETCH
    logic [TO_W-1:0]     tmo_q, tmo_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic                retire;

    logic                ir_load_q, ir_load_d;
    logic                pc_en_q, pc_en_d;
    logic                br_q, br_d;
    logic                regw_q, regw_d;
    logic [ALUOP_W-1:0]  aluop_q, aluop_d;
    logic                mem_req_q, mem_req_d;
    logic                memw_q, memw_d;
    logic [1:0]          accdata_q, accdata_d;
    logic                accw_q, accw_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                sb_done_c;

    // State, captured instruction, timeout, counter and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            insn_q    <= '0;
            tmo_q     <= '0;
            retired_q <= '0;
            ir_load_q <= 1'b0;
            pc_en_q   <= 1'b0;
            br_q      <= 1'b0;
            regw_q    <= 1'b0;
            aluop_q   <= '0;
            mem_req_q <= 1'b0;
            memw_q    <= 1'b0;
            accdata_q <= 2'b00;
            accw_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            insn_q    <= insn_d;
            tmo_q     <= tmo_d;
            retired_q <= retired_d;
            ir_load_q <= ir_load_d;
            pc_en_q   <= pc_en_d;
            br_q      <= br_d;
            regw_q    <= regw_d;
            aluop_q   <= aluop_d;
            mem_req_q <= mem_req_d;
            memw_q    <= memw_d;
            accdata_q <= accdata_d;
            accw_q    <= accw_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next state, then strobes decoded from the next state so the registered
    // outputs line up with the state they belong to
    always_comb begin
        state_d   = state_q;
        insn_d    = insn_q;
        tmo_d     = tmo_q;
        retire    = 1'b0;
        ir_load_d = 1'b0;
        pc_en_d   = 1'b0;
        br_d      = 1'b0;
        regw_d    = 1'b0;
        aluop_d   = '0;
        mem_req_d = 1'b0;
        memw_d    = 1'b0;
        accdata_d = 2'b00;
        accw_d    = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                insn_d  = {typ, op};
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (insn_q[4]) begin
                    state_d = S_EXEC;
                end else if (insn_q[3:0] == OP_LB || insn_q[3:0] == OP_SB) begin
                    state_d = S_MEM;
                end else if (insn_q[3:0] == OP_HALT) begin
                    state_d = S_HALT;
                    retire  = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM: begin
                // An ack arriving on the final allowed cycle still completes
                if (mem_ack) begin
                    tmo_d = '0;
                    if (insn_q[3:0] == OP_LB) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (tmo_q == TO_W'(MEM_TIMEOUT - 1)) begin
                    tmo_d   = '0;
                    state_d = S_FAULT;
                end else begin
                    tmo_d = tmo_q + TO_W'(1);
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                if (start) state_d = S_FETCH;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        unique case (state_d)
            S_FETCH: begin
                ir_load_d = 1'b1;
                busy_d    = 1'b1;
            end
            S_DECODE: begin
                busy_d = 1'b1;
            end
            S_EXEC: begin
                busy_d  = 1'b1;
                pc_en_d = 1'b1;
                if (insn_d[4]) begin
                    accw_d    = 1'b1;
                    accdata_d = 2'b00;
                end else if (insn_d[3:0] == OP_STORE) begin
                    regw_d = 1'b1;
                end else if (insn_d[3:0] == OP_PUT) begin
                    accw_d    = 1'b1;
                    accdata_d = 2'b10;
                end else if (insn_d[3:0] == OP_BTR || insn_d[3:0] == OP_JMP) begin
                    br_d = 1'b1;
                end else if (insn_d[3:0] >= OP_ADD && insn_d[3:0] <= OP_GTR) begin
                    // ALU opcodes are contiguous, so the ALU code is the offset from ADD
                    aluop_d   = ALUOP_W'(3'(insn_d[3:0] - OP_ADD));
                    accw_d    = 1'b1;
                    accdata_d = 2'b11;
                end
            end
            S_MEM: begin
                busy_d    = 1'b1;
                mem_req_d = 1'b1;
                memw_d    = (insn_d[3:0] == OP_SB);
            end
            S_WB: begin
                busy_d    = 1'b1;
                pc_en_d   = 1'b1;
                accw_d    = 1'b1;
                accdata_d = 2'b01;
            end
            S_HALT:  done_d = 1'b1;
            S_FAULT: err_d  = 1'b1;
            default: ;
        endcase

        retired_d = (retire && retired_q != '1) ? retired_q + CNT_W'(1) : retired_q;
    end

    // SB retires in its ack cycle, so its PC advance follows mem_ack directly
    assign sb_done_c = (state_q == S_MEM) && (insn_q[3:0] == OP_SB) && mem_ack;

    assign ir_load       = ir_load_q;
    assign pc_en         = pc_en_q | sb_done_c;
    assign br_ctrl       = br_q;
    assign regwrite_ctrl = regw_q;
    assign aluop_ctrl    = aluop_q;
    assign mem_req       = mem_req_q;
    assign memwrite_ctrl = memw_q;
    assign accdata_ctrl  = accdata_q;
    assign accwrite_ctrl = accw_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
`timescale 1ns/1ps
// Bench for multicycle_controller: random instruction streams compared cycle by
// cycle against a per-instruction schedule derived from the instruction set.
module tb_multicycle_controller;

    localparam int TIMEOUT = 15;
    localparam int B_IR = 14, B_PC = 13, B_BR = 12, B_RW = 11;
    localparam int B_MREQ = 7, B_MW = 6, B_AW = 3, B_BUSY = 2, B_DONE = 1, B_ERR = 0;

    logic clk = 1'b0;
    logic rst_n, start, typ, mem_ack;
    logic [3:0] op;
    logic ir_load, pc_en, br_ctrl, regwrite_ctrl, mem_req, memwrite_ctrl;
    logic accwrite_ctrl, busy, done, err;
    logic [2:0] aluop_ctrl;
    logic [1:0] accdata_ctrl;
    logic [15:0] retired;

    logic s_rst_n, s_start, s_typ, s_mem_ack;
    logic [3:0] s_op;
    logic s_ir_load, s_pc_en, s_br, s_rw, s_mreq, s_mw, s_aw, s_busy, s_done, s_err;
    logic [2:0] s_aluop;
    logic [1:0] s_accdata;
    logic [1:0] s_retired;

    int checks = 0;
    int failures = 0;
    int exp_ret = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.ALUOP_W(3), .CNT_W(16), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .typ(typ), .op(op), .mem_ack(mem_ack),
        .ir_load(ir_load), .pc_en(pc_en), .br_ctrl(br_ctrl), .regwrite_ctrl(regwrite_ctrl),
        .aluop_ctrl(aluop_ctrl), .mem_req(mem_req), .memwrite_ctrl(memwrite_ctrl),
        .accdata_ctrl(accdata_ctrl), .accwrite_ctrl(accwrite_ctrl), .busy(busy),
        .done(done), .err(err), .retired(retired)
    );

    multicycle_controller #(.ALUOP_W(3), .CNT_W(2), .MEM_TIMEOUT(TIMEOUT)) dut_sat (
        .clk(clk), .rst_n(s_rst_n), .start(s_start), .typ(s_typ), .op(s_op), .mem_ack(s_mem_ack),
        .ir_load(s_ir_load), .pc_en(s_pc_en), .br_ctrl(s_br), .regwrite_ctrl(s_rw),
        .aluop_ctrl(s_aluop), .mem_req(s_mreq), .memwrite_ctrl(s_mw),
        .accdata_ctrl(s_accdata), .accwrite_ctrl(s_aw), .busy(s_busy),
        .done(s_done), .err(s_err), .retired(s_retired)
    );

    function automatic logic [14:0] got();
        return {ir_load, pc_en, br_ctrl, regwrite_ctrl, aluop_ctrl, mem_req, memwrite_ctrl,
                accdata_ctrl, accwrite_ctrl, busy, done, err};
    endfunction

    // Expected strobes for the single execute cycle of a non-memory instruction
    function automatic logic [14:0] exec_vec(input logic t, input logic [3:0] o);
        logic [14:0] e;
        e = '0;
        e[B_PC] = 1'b1;
        e[B_BUSY] = 1'b1;
        if (t) begin
            e[B_AW] = 1'b1;
        end else if (o == 4'd0) begin
            e[B_RW] = 1'b1;
        end else if (o == 4'd3) begin
            e[B_AW] = 1'b1;
            e[5:4] = 2'b10;
        end else if (o == 4'd4 || o == 4'd5) begin
            e[B_BR] = 1'b1;
        end else if (o >= 4'd6 && o <= 4'd13) begin
            e[10:8] = 3'(o - 4'd6);
            e[B_AW] = 1'b1;
            e[5:4] = 2'b11;
        end
        return e;
    endfunction

    // One instruction starting in FETCH. n = MEM cycle carrying the ack (0 = never),
    // hw = idle HALT cycles before the resuming start pulse.
    task automatic run_instr(input logic t, input logic [3:0] o, input int n, input int hw);
        logic [14:0] eq[$];
        int aq[$];    // 0/1 forced mem_ack, 2 = random
        int sq[$];    // 0/1 forced start, 2 = random
        bit rq[$];    // instruction retires at the end of this cycle
        logic [14:0] e;
        bit is_mem;
        int m;
        e = '0; e[B_IR] = 1'b1; e[B_BUSY] = 1'b1;
        eq.push_back(e); aq.push_back(2); sq.push_back(2); rq.push_back(1'b0);
        e = '0; e[B_BUSY] = 1'b1;
        eq.push_back(e); aq.push_back(2); sq.push_back(2); rq.push_back(!t && o == 4'd15);
        is_mem = !t && (o == 4'd1 || o == 4'd2);
        if (!t && o == 4'd15) begin
            e = '0; e[B_DONE] = 1'b1;
            for (int k = 0; k < hw; k++) begin
                eq.push_back(e); aq.push_back(2); sq.push_back(0); rq.push_back(1'b0);
            end
            eq.push_back(e); aq.push_back(2); sq.push_back(1); rq.push_back(1'b0);
        end else if (is_mem) begin
            m = (n == 0) ? TIMEOUT : n;
            for (int k = 1; k <= m; k++) begin
                e = '0;
                e[B_MREQ] = 1'b1; e[B_BUSY] = 1'b1;
                e[B_MW] = (o == 4'd2);
                e[B_PC] = (o == 4'd2) && (k == n);
                eq.push_back(e); aq.push_back(k == n ? 1 : 0); sq.push_back(2);
                rq.push_back((o == 4'd2) && (k == n));
            end
            if (n == 0) begin
                e = '0; e[B_ERR] = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    eq.push_back(e); aq.push_back(2); sq.push_back(1); rq.push_back(1'b0);
                end
            end else if (o == 4'd1) begin
                e = '0;
                e[B_PC] = 1'b1; e[B_AW] = 1'b1; e[5:4] = 2'b01; e[B_BUSY] = 1'b1;
                eq.push_back(e); aq.push_back(2); sq.push_back(2); rq.push_back(1'b1);
            end
        end else begin
            eq.push_back(exec_vec(t, o)); aq.push_back(2); sq.push_back(2); rq.push_back(1'b1);
        end

        for (int i = 0; i < eq.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                typ = t;
                op = o;
            end else begin
                typ = 1'($urandom);
                op = 4'($urandom);
            end
            start = (sq[i] == 2) ? 1'($urandom) : 1'(sq[i]);
            mem_ack = (aq[i] == 2) ? 1'($urandom) : 1'(aq[i]);
            #1;
            checks++;
            if (got() !== eq[i]) begin
                failures++;
                $display("FAIL strobes typ=%0d op=%0d cyc=%0d got=%h exp=%h", t, o, i, got(), eq[i]);
            end
            checks++;
            if (retired !== 16'(exp_ret)) begin
                failures++;
                $display("FAIL retired typ=%0d op=%0d cyc=%0d got=%0d exp=%0d", t, o, i, retired, exp_ret);
            end
            if (rq[i] && exp_ret < 65535) exp_ret++;
        end
    endtask

    // One IDLE cycle with start asserted
    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        typ = 1'($urandom);
        op = 4'($urandom);
        mem_ack = 1'($urandom);
        #1;
        checks++;
        if (got() !== 15'd0 || retired !== 16'(exp_ret)) begin
            failures++;
            $display("FAIL idle_kick got=%h ret=%0d exp=0 ret=%0d", got(), retired, exp_ret);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        typ = 1'b0; op = 4'd6; mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (got() !== 15'd0 || retired !== 16'd0) begin
            failures++;
            $display("FAIL reset_hold got=%h ret=%0d exp=0", got(), retired);
        end
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (got() !== 15'd0 || retired !== 16'd0) begin
            failures++;
            $display("FAIL reset_idle got=%h ret=%0d exp=0", got(), retired);
        end
        exp_ret = 0;
    endtask

    task automatic test_alu();
        kick();
        run_instr(1'b0, 4'd6, 0, 0);
    endtask

    task automatic test_lb();
        run_instr(1'b0, 4'd1, 3, 0);
        run_instr(1'b0, 4'd2, 1, 0);
        run_instr(1'b0, 4'd1, TIMEOUT, 0);
    endtask

    task automatic test_halt();
        run_instr(1'b0, 4'd15, 3, 0);
        run_instr(1'b0, 4'd15, 0, 0);
        run_instr(1'b1, 4'd15, 0, 0);
    endtask

    task automatic test_random();
        logic t;
        logic [3:0] o;
        for (int i = 0; i < 40; i++) begin
            t = 1'($urandom);
            o = 4'($urandom);
            run_instr(t, o, int'($urandom_range(1, TIMEOUT)), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_reset_mid_mem();
        @(negedge clk);
        typ = 1'b0; op = 4'd2; start = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        op = 4'd6;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b1 || memwrite_ctrl !== 1'b1) begin
            failures++;
            $display("FAIL mid_mem_entry mem_req=%b memwrite=%b exp=1 1", mem_req, memwrite_ctrl);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (got() !== 15'd0 || retired !== 16'd0) begin
            failures++;
            $display("FAIL mid_mem_reset got=%h ret=%0d exp=0", got(), retired);
        end
        exp_ret = 0;
        @(negedge clk);
        start = 1'b1; mem_ack = 1'b1;
        #1;
        checks++;
        if (got() !== 15'd0) begin
            failures++;
            $display("FAIL reset_start_ignored got=%h exp=0", got());
        end
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (got() !== 15'd0) begin
            failures++;
            $display("FAIL post_reset_idle got=%h exp=0", got());
        end
        kick();
        run_instr(1'b0, 4'd9, 0, 0);
    endtask

    task automatic test_timeout();
        run_instr(1'b0, 4'd2, 0, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL fault_reset err=%b exp=0", err);
        end
        exp_ret = 0;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
    endtask

    task automatic test_saturation();
        int want;
        s_typ = 1'b0; s_op = 4'd14; s_mem_ack = 1'b0;
        @(negedge clk);
        s_rst_n = 1'b1;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (3) @(negedge clk);
            #1;
            want = (i + 1 > 3) ? 3 : i + 1;
            checks++;
            if (s_retired !== 2'(want)) begin
                failures++;
                $display("FAIL saturate instr=%0d got=%0d exp=%0d", i + 1, s_retired, want);
            end
        end
    endtask

    initial begin
        s_rst_n = 1'b0; s_start = 1'b0; s_typ = 1'b0; s_op = 4'd0; s_mem_ack = 1'b0;
        test_reset();
        test_alu();
        test_lb();
        test_halt();
        test_random();
        test_reset_mid_mem();
        test_random();
        test_timeout();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
